// File: rtl/xhdmiin_wordalign.sv
// xhdmiin_wordalign: barrel-shift raw deserializer words into TMDS character alignment, hunting for sync tokens to lock
//   i_clk          in   word clock
//   i_reset        in   asynchronous active-high reset
//   i_word         in   raw WIDTH-bit word, new every cycle
//   o_word         out  aligned word
//   o_sync         out  o_word is one of SYNC_WORDS
//   o_locked       out  alignment locked
//   o_shift        out  current bit shift (0..WIDTH-1)
//   o_slips        out  count of shift changes, wrapping
//   i_manual       in   hold shift manually (XHDMIIN_WORDALIGN_MANUAL_EN only)
//   i_manual_shift in   manual shift value, clamped to WIDTH-1 (XHDMIIN_WORDALIGN_MANUAL_EN only)
module xhdmiin_wordalign #(
    parameter int WIDTH = 10,
    parameter logic [4*WIDTH-1:0] SYNC_WORDS = {10'h354, 10'h0ab, 10'h154, 10'h2ab},
    parameter int SEARCH_TIMEOUT = 64,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
`ifdef XHDMIIN_WORDALIGN_MANUAL_EN
    input  logic                     i_manual,
    input  logic [$clog2(WIDTH)-1:0] i_manual_shift,
`endif
    input  logic [WIDTH-1:0]         i_word,
    output logic [WIDTH-1:0]         o_word,
    output logic                     o_sync,
    output logic                     o_locked,
    output logic [$clog2(WIDTH)-1:0] o_shift,
    output logic [15:0]              o_slips
);
    localparam int SW = $clog2(WIDTH);
    localparam int TW = $clog2(LOSS_TIMEOUT > SEARCH_TIMEOUT ? LOSS_TIMEOUT : SEARCH_TIMEOUT);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]   prev, win;
    logic [2*WIDTH-1:0] cat;
    logic [TW-1:0]      timer, timer_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [SW-1:0]      shift_n;
    logic               match, slip, bump, locked_n, search_end;

    assign cat = {i_word, prev};
    assign win = cat[o_shift +: WIDTH];
    assign search_end = timer == TW'(SEARCH_TIMEOUT - 1);

    always_comb begin
        match = 1'b0;
        for (int k = 0; k < 4; k++)
            match = match | (win == SYNC_WORDS[k*WIDTH +: WIDTH]);
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer + TW'(1);
        cnt_n    = cnt;
        slip     = 1'b0;
        locked_n = o_locked;
        case (state)
            SEARCH:
                if (match) begin
                    state_n = CONFIRM;
                    cnt_n   = CW'(1);
                    timer_n = '0;
                end else if (search_end)
                    slip = 1'b1;
            CONFIRM:
                // a match landing on the timeout cycle still counts toward lock
                if (cnt + CW'(match) == CW'(LOCK_COUNT)) begin
                    state_n  = LOCKED;
                    locked_n = 1'b1;
                    timer_n  = '0;
                end else if (search_end) begin
                    slip    = 1'b1;
                    state_n = SEARCH;
                    cnt_n   = '0;
                end else
                    cnt_n = cnt + CW'(match);
            LOCKED:
                if (match)
                    timer_n = '0;
                else if (timer == TW'(LOSS_TIMEOUT - 1)) begin
                    state_n  = SEARCH;
                    locked_n = 1'b0;
                    cnt_n    = '0;
                    timer_n  = '0;
                end
            default: state_n = SEARCH;
        endcase
        if (slip)
            timer_n = '0;
        shift_n = slip ? (o_shift == SW'(WIDTH - 1) ? '0 : o_shift + SW'(1)) : o_shift;
`ifdef XHDMIIN_WORDALIGN_MANUAL_EN
        if (i_manual) begin
            state_n  = SEARCH;
            timer_n  = '0;
            cnt_n    = '0;
            locked_n = 1'b0;
            shift_n  = ({1'b0, i_manual_shift} >= (SW+1)'(WIDTH)) ? SW'(WIDTH - 1) : i_manual_shift;
        end
        bump = shift_n != o_shift;
`else
        bump = slip;
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= SEARCH;
            timer    <= '0;
            cnt      <= '0;
            prev     <= '0;
            o_word   <= '0;
            o_sync   <= 1'b0;
            o_locked <= 1'b0;
            o_shift  <= '0;
            o_slips  <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            cnt      <= cnt_n;
            prev     <= i_word;
            o_word   <= win;
            o_sync   <= match;
            o_locked <= locked_n;
            o_shift  <= shift_n;
            o_slips  <= o_slips + 16'(bump);
        end
    end
endmodule

// File: tb/tb_xhdmiin_wordalign.sv
// tb_xhdmiin_wordalign: vector table plus model-checked random and directed streams for xhdmiin_wordalign
module tb_xhdmiin_wordalign;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [9:0] i_word = '0;
    logic [9:0] o_word;
    logic       o_sync, o_locked;
    logic [3:0] o_shift;
    logic [15:0] o_slips;
`ifdef XHDMIIN_WORDALIGN_MANUAL_EN
    logic       i_manual = 1'b0;
    logic [3:0] i_manual_shift = '0;
`endif

    xhdmiin_wordalign dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
`ifdef XHDMIIN_WORDALIGN_MANUAL_EN
        .i_manual(i_manual),
        .i_manual_shift(i_manual_shift),
`endif
        .i_word(i_word),
        .o_word(o_word),
        .o_sync(o_sync),
        .o_locked(o_locked),
        .o_shift(o_shift),
        .o_slips(o_slips)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;

    logic [9:0] toks [4] = '{10'h354, 10'h0ab, 10'h154, 10'h2ab};
    logic [9:0] m_prev, m_word, a_prev;
    bit         m_sync, m_locked;
    int         m_shift, m_slips, m_mode, m_timer, m_cnt;

    typedef struct {
        logic [9:0] w;
        logic [9:0] ew;
        bit         es;
    } vec_t;
    vec_t tv [7];

    function automatic bit is_tok(input logic [9:0] w);
        return w == 10'h354 || w == 10'h0ab || w == 10'h154 || w == 10'h2ab;
    endfunction

    function automatic logic [9:0] rnd_nt();
        logic [9:0] r;
        do r = 10'($urandom); while (is_tok(r));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_word = '0; m_sync = 0; m_locked = 0;
        m_shift = 0; m_slips = 0; m_mode = 0; m_timer = 0; m_cnt = 0;
    endtask

    // mode: 0 hunting, 1 counting tokens, 2 locked
    task automatic model_step(input logic [9:0] w, input bit man, input int msh);
        logic [19:0] c;
        logic [9:0]  win;
        bit          hit, slip;
        c = {w, m_prev};
        win = 10'(c >> m_shift);
        hit = is_tok(win);
        slip = 0;
        if (man) begin
            int nsh = msh > 9 ? 9 : msh;
            if (nsh != m_shift) m_slips = (m_slips + 1) % 65536;
            m_shift = nsh; m_mode = 0; m_timer = 0; m_cnt = 0; m_locked = 0;
        end else begin
            if (m_mode == 0) begin
                if (hit) begin m_mode = 1; m_cnt = 1; m_timer = 0; end
                else if (m_timer == 63) slip = 1;
                else m_timer++;
            end else if (m_mode == 1) begin
                m_cnt += int'(hit);
                if (m_cnt == 4) begin m_mode = 2; m_locked = 1; m_timer = 0; end
                else if (m_timer == 63) begin slip = 1; m_mode = 0; m_cnt = 0; end
                else m_timer++;
            end else begin
                if (hit) m_timer = 0;
                else if (m_timer == 4095) begin m_mode = 0; m_locked = 0; m_cnt = 0; m_timer = 0; end
                else m_timer++;
            end
            if (slip) begin
                m_shift = (m_shift + 1) % 10;
                m_slips = (m_slips + 1) % 65536;
                m_timer = 0;
            end
        end
        m_prev = w; m_word = win; m_sync = hit;
    endtask

    task automatic cyc(input logic [9:0] w, input bit man = 0, input int msh = 0);
        @(negedge i_clk);
        i_word = w;
`ifdef XHDMIIN_WORDALIGN_MANUAL_EN
        i_manual = man;
        i_manual_shift = 4'(msh);
`endif
        model_step(w, man, msh);
        @(posedge i_clk);
        #1;
        check("cycle", {o_word, o_sync, o_locked, o_shift, o_slips},
              {m_word, m_sync, m_locked, 4'(m_shift), 16'(m_slips)});
    endtask

    // raw word whose window at shift s, one cycle later, is the aligned word a
    task automatic acyc(input logic [9:0] a, input int s);
        logic [19:0] t;
        t = {a, a_prev} >> (10 - s);
        a_prev = a;
        cyc(t[9:0]);
    endtask

    task automatic do_reset();
        #2 i_reset = 1'b1;
        #1 check("async_reset", {o_word, o_sync, o_locked, o_shift, o_slips}, 32'h0);
        model_reset();
        @(posedge i_clk);
        #1 check("reset_edge", {o_word, o_sync, o_locked, o_shift, o_slips}, 32'h0);
        i_reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit saw_lock, saw_wrap;
        logic [3:0] ps;
        int s;
        tv[0] = '{10'h354, 10'h000, 0};
        tv[1] = '{10'h354, 10'h354, 1};
        tv[2] = '{10'h0ab, 10'h354, 1};
        tv[3] = '{10'h155, 10'h0ab, 1};
        tv[4] = '{10'h2ab, 10'h155, 0};
        tv[5] = '{10'h154, 10'h2ab, 1};
        tv[6] = '{10'h000, 10'h154, 1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(tv[i].w);
            check("tbl_word", o_word, tv[i].ew);
            check("tbl_sync", o_sync, tv[i].es);
        end

        // tokens aligned only at shift 3: hunt 0,1,2,3 then lock
        do_reset();
        a_prev = 10'h354;
        for (int k = 0; k < 198 && !o_locked; k++) acyc(10'h354, 3);
        check("t2_locked", o_locked, 1);
        check("t2_shift", o_shift, 3);
        check("t2_slips", o_slips, 3);

        // loss of lock after 4096 token-free windows
        for (int k = 0; k < 4096; k++) acyc(rnd_nt(), 3);
        check("t3_hold", o_locked, 1);
        acyc(rnd_nt(), 3);
        check("t3_loss", o_locked, 0);
        check("t3_shift", o_shift, 3);

        // three tokens per window never lock; shift wraps
        saw_lock = 0; saw_wrap = 0;
        for (int b = 0; b < 6; b++)
            for (int j = 0; j < 128; j++) begin
                ps = o_shift;
                acyc(j < 3 ? 10'h354 : 10'h000, 3);
                if (o_locked) saw_lock = 1;
                if (ps == 4'd9 && o_shift == 4'd0) saw_wrap = 1;
            end
        check("t4_no_lock", saw_lock, 0);
        check("t4_wrap", saw_wrap, 1);

        for (int k = 0; k < 1500; k++) cyc(10'($urandom));

        // random tokens at a random phase, then reset while locked
        do_reset();
        s = $urandom_range(0, 9);
        a_prev = toks[$urandom_range(0, 3)];
        for (int k = 0; k < 1500 && !o_locked; k++) acyc(toks[$urandom_range(0, 3)], s);
        check("rnd_locked", o_locked, 1);
        for (int k = 0; k < 20; k++) acyc(toks[$urandom_range(0, 3)], s);
        do_reset();
        for (int k = 0; k < 50; k++) cyc(10'($urandom));

`ifdef XHDMIIN_WORDALIGN_MANUAL_EN
        a_prev = 10'h354;
        acyc(10'h354, 3);
        cyc(10'h0, 1, 12);
        cyc(10'h0, 1, 12);
        check("man_shift", o_shift, 9);
        check("man_locked", o_locked, 0);
        a_prev = 10'h354;
        for (int k = 0; k < 400 && !o_locked; k++) acyc(10'h354, 3);
        check("man_relock", o_locked, 1);
        check("man_relock_shift", o_shift, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
